// File: rtl/alu_muldiv_seq_pkg.sv
// Shared ALU opcode constants and controller state encoding for alu_muldiv_seq.
// Latency: n/a (package only).
// Backpressure: n/a.
package alu_muldiv_seq_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_OR   = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_XOR  = 3'b011,
        ALU_SLL  = 3'b100,
        ALU_SRL  = 3'b101,
        ALU_SUB  = 3'b110,
        ALU_CMPU = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV_CMP,
        ST_DIV_SUB,
        ST_FIN
    } state_e;

endpackage

// File: rtl/muldiv_carry32.sv
// Unsigned carry-out of a 32-bit add, reconstructed from operands and sum.
// Latency: combinational.
// Backpressure: none.
module muldiv_carry32
    import alu_muldiv_seq_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] sum,
    output logic            carry
);

    logic [XLEN-1:0] gen;

    // Carry into bit i+1: generate, or propagate when the sum bit shows an incoming carry.
    assign gen   = (a & b) | ((a | b) & ~sum);
    assign carry = gen[XLEN-1];

endmodule

// File: rtl/alu_muldiv_seq.sv
// Sequential unsigned 32x32 multiply / 32/32 divide driving the shared datapath ALU.
// Latency: MUL 33 cycles, DIV 65 cycles, divide-by-zero 1 cycle from the accepting edge.
// Backpressure: start is only accepted in IDLE; busy stalls the pipeline until done.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            op_div,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_op,
    input  logic [XLEN-1:0] alu_res,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic            div_zero
);

    state_e          state;
    state_e          state_nxt;
    logic [4:0]      cnt;
    logic [XLEN-1:0] opb_q;
    logic            ge;
    logic            carry;
    logic [XLEN-1:0] rem_sh;

    // Partial remainder shifted left by one; its lost MSB is folded into ge.
    assign rem_sh = {hi[XLEN-2:0], lo[XLEN-1]};

    muldiv_carry32 u_carry (
        .a     (alu_a),
        .b     (alu_b),
        .sum   (alu_res),
        .carry (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        alu_a     = '0;
        alu_b     = '0;
        alu_op    = ALU_ADD;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (!op_div)           state_nxt = ST_MUL;
                    else if (opb == '0)    state_nxt = ST_FIN;
                    else                   state_nxt = ST_DIV_CMP;
                end
            end
            ST_MUL: begin
                alu_op = ALU_ADD;
                alu_a  = hi;
                alu_b  = lo[0] ? opb_q : '0;
                if (cnt == 5'd31) state_nxt = ST_FIN;
            end
            ST_DIV_CMP: begin
                alu_op    = ALU_CMPU;
                alu_a     = rem_sh;
                alu_b     = opb_q;
                state_nxt = ST_DIV_SUB;
            end
            ST_DIV_SUB: begin
                alu_op    = ALU_SUB;
                alu_a     = hi;
                alu_b     = opb_q;
                state_nxt = (cnt == 5'd31) ? ST_FIN : ST_DIV_CMP;
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_FIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            cnt      <= '0;
            opb_q    <= '0;
            ge       <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        opb_q    <= opb;
                        div_zero <= 1'b0;
                        if (op_div && (opb == '0)) begin
                            hi       <= opa;
                            lo       <= '1;
                            div_zero <= 1'b1;
                        end else begin
                            hi <= '0;
                            lo <= opa;
                        end
                    end
                end
                ST_MUL: begin
                    hi  <= {carry, alu_res[XLEN-1:1]};
                    lo  <= {alu_res[0], lo[XLEN-1:1]};
                    cnt <= cnt + 5'd1;
                end
                ST_DIV_CMP: begin
                    ge <= hi[XLEN-1] | alu_res[0];
                    hi <= rem_sh;
                    lo <= {lo[XLEN-2:0], 1'b0};
                end
                ST_DIV_SUB: begin
                    // Modulo-2^32 wrap is exact when ge came from the shifted-out MSB.
                    if (ge) begin
                        hi    <= alu_res;
                        lo[0] <= 1'b1;
                    end
                    cnt <= cnt + 5'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed table-driven bench for alu_muldiv_seq with a behavioural shared ALU.
module tb_alu_muldiv_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op_div;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_res;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int n_cmp = 0;
    int n_err = 0;

    alu_muldiv_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_div   (op_div),
        .opa      (opa),
        .opb      (opb),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_op   (alu_op),
        .alu_res  (alu_res),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        case (alu_op)
            3'b010:  alu_res = alu_a + alu_b;
            3'b110:  alu_res = alu_a - alu_b;
            3'b111:  alu_res = {31'b0, (alu_a >= alu_b)};
            default: alu_res = '0;
        endcase
    end

    typedef struct {
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one operation; optional stray start mid-run (inj_cyc>0) and in the FIN cycle.
    task automatic run_op(input logic d, input logic [31:0] a, input logic [31:0] b,
                          input int inj_cyc, input bit inj_fin,
                          output int lat, output bit busy_ok);
        @(negedge clk);
        start = 1'b1; op_div = d; opa = a; opb = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        busy_ok = 1'b1;
        for (int c = 1; c < 200; c++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (inj_cyc > 0 && c == inj_cyc) begin
                start = 1'b1; op_div = 1'b1; opa = 32'd1; opb = 32'd0;
            end
            if (inj_cyc > 0 && c == inj_cyc + 1) start = 1'b0;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        if (inj_fin) begin
            start = 1'b1; op_div = 1'b0; opa = 32'd2; opb = 32'd2;
        end
        @(posedge clk); #1;
        start = 1'b0;
        if (busy !== 1'b0 || done !== 1'b0) busy_ok = 1'b0;
    endtask

    initial begin
        int  lat;
        bit  bok;
        int  extra;

        vecs[0]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
        vecs[1]  = '{1'b0, 32'd12345,     32'd0,         32'd0,         32'd0,         1'b0, 33};
        vecs[2]  = '{1'b0, 32'h8000_0000, 32'd2,         32'd1,         32'd0,         1'b0, 33};
        vecs[3]  = '{1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 65};
        vecs[4]  = '{1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'd1,         1'b0, 65};
        vecs[5]  = '{1'b1, 32'd55,        32'd0,         32'd55,        32'hFFFF_FFFF, 1'b1, 1};
        vecs[6]  = '{1'b0, 32'd3,         32'd5,         32'd0,         32'd15,        1'b0, 33};
        vecs[7]  = '{1'b1, 32'h1234_5678, 32'h10,        32'd8,         32'h0123_4567, 1'b0, 65};
        vecs[8]  = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         1'b0, 33};
        vecs[9]  = '{1'b1, 32'd5,         32'd9,         32'd5,         32'd0,         1'b0, 65};
        vecs[10] = '{1'b1, 32'd7,         32'd1,         32'd0,         32'd7,         1'b0, 65};

        rst_n = 1'b0; start = 1'b0; op_div = 1'b0; opa = '0; opb = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy",  {63'b0, busy}, 64'd0);
        chk("reset_done",  {63'b0, done}, 64'd0);
        chk("reset_hilo",  {hi, lo}, 64'd0);
        chk("reset_dz",    {63'b0, div_zero}, 64'd0);
        chk("reset_alu",   {alu_a, alu_b[28:0], alu_op}, {64'd0 | 64'd2});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].d, vecs[i].a, vecs[i].b, 0, 1'b0, lat, bok);
            chk($sformatf("v%0d_lat", i),  lat, vecs[i].lat);
            chk($sformatf("v%0d_hi", i),   {32'b0, hi}, {32'b0, vecs[i].hi});
            chk($sformatf("v%0d_lo", i),   {32'b0, lo}, {32'b0, vecs[i].lo});
            chk($sformatf("v%0d_dz", i),   {63'b0, div_zero}, {63'b0, vecs[i].dz});
            chk($sformatf("v%0d_busy", i), {63'b0, bok}, 64'd1);
        end

        // Stray starts during MUL and during FIN must be ignored.
        run_op(1'b0, 32'd7, 32'd9, 10, 1'b1, lat, bok);
        chk("inj_lat",  lat, 33);
        chk("inj_res",  {hi, lo}, 64'd63);
        chk("inj_dz",   {63'b0, div_zero}, 64'd0);
        chk("inj_busy", {63'b0, bok}, 64'd1);
        extra = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) extra++;
        end
        chk("inj_extra_done", extra, 0);
        chk("inj_hold", {hi, lo}, 64'd63);

        // Reset mid-divide abandons the operation asynchronously.
        @(negedge clk);
        start = 1'b1; op_div = 1'b1; opa = 32'd100; opb = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        chk("pre_rst_busy", {63'b0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_dz",   {63'b0, div_zero}, 64'd0);
        chk("rst_alu",  {alu_a, alu_b[28:0], alu_op}, {64'd0 | 64'd2});
        @(negedge clk);
        rst_n = 1'b1;

        run_op(1'b0, 32'd3, 32'd5, 0, 1'b0, lat, bok);
        chk("post_rst_lat", lat, 33);
        chk("post_rst_lo",  {32'b0, lo}, 64'd15);
        chk("post_rst_hi",  {32'b0, hi}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Multi-cycle controller that runs unsigned 32×32→64 multiplication and unsigned 32/32 division on the shared 32-bit ALU instead of dedicated multiply/divide arrays. It sits beside the ALU in the CPU datapath: it drives the ALU operand and opcode inputs while busy, reads back the ALU result, and returns a registered 64-bit result with a one-cycle done pulse. Pipeline control stalls on `busy`.

## Interface
Parameters:
- none; width fixed at 32, iteration count fixed at 32.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `op_div`  in  1  0 = multiply, 1 = divide; sampled with `start`.
- `opa`  in  32  multiplicand / dividend.
- `opb`  in  32  multiplier / divisor.
- `alu_a`  out  32  ALU operand A.
- `alu_b`  out  32  ALU operand B.
- `alu_op`  out  3  ALU opcode.
- `alu_res`  in  32  ALU result, combinational from `alu_a`/`alu_b`/`alu_op`.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`, inclusive.
- `done`  out  1  one-cycle pulse; result valid.
- `hi`  out  32  MUL: product[63:32]; DIV: remainder.
- `lo`  out  32  MUL: product[31:0]; DIV: quotient.
- `div_zero`  out  1  set with `done` when the divisor was 0; cleared on the next accepted `start`.

## Operation
- ALU opcodes used: 3'b010 ADD, 3'b110 SUB, 3'b111 SLTU-style compare (`alu_res[0]` = 1 iff A ≥ B unsigned, i.e. carry of A−B). In IDLE/FIN, drive `alu_a`=0, `alu_b`=0, `alu_op`=3'b010.
- States: IDLE, MUL, DIV_CMP, DIV_SUB, FIN. 5-bit iteration counter `cnt`.
- IDLE + `start`:
  - MUL: `hi`=0, `lo`=`opa`, latch `opb` as `mcand`, `cnt`=0, go to MUL.
  - DIV with `opb`≠0: `hi`=0, `lo`=`opa`, latch divisor, go to DIV_CMP.
  - DIV with `opb`=0: `hi`=`opa`, `lo`=32'hFFFF_FFFF, `div_zero`=1, go to FIN.
- MUL, one cycle per iteration:
  - `alu_op`=ADD, `alu_a`=`hi`, `alu_b`=`lo[0]` ? `mcand` : 0.
  - carry = MSB of (a&b | (a|b)&~res), computed locally.
  - {`hi`,`lo`} ← {carry, `alu_res`, `lo[31:1]`}.
  - `cnt`++; after `cnt`=31 go to FIN.
- DIV_CMP:
  - r = {`hi[30:0]`, `lo[31]`}; `alu_op`=compare, `alu_a`=r, `alu_b`=divisor.
  - ge ← `hi[31]` | `alu_res[0]`; `hi` ← r; `lo` ← {`lo[30:0]`,0}; go to DIV_SUB.
- DIV_SUB:
  - `alu_op`=SUB, `alu_a`=`hi`, `alu_b`=divisor.
  - If ge: `hi` ← `alu_res`, `lo[0]` ← 1.
  - `cnt`++; after `cnt`=31 go to FIN, else DIV_CMP.
  - 32-bit wrap of SUB is correct when ge came from the shifted-out MSB.
- FIN: `done`=1 for one cycle, then go to IDLE. `hi`/`lo` hold until the next accepted `start`.
- `start` outside IDLE (including in FIN) is ignored. No abort input.

## Timing
- Count from the edge that samples `start` (edge 0):
  - MUL: `done` high in cycle 33.
  - DIV: `done` high in cycle 65.
  - Divide by zero: `done` high in cycle 1.
- Back-to-back: the earliest next `start` is sampled in the IDLE cycle after FIN.
- Reset values: state IDLE, `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0, `cnt`=0, ALU outputs per IDLE.
- Reset asserted mid-operation abandons the operation immediately. No `done` is produced.

## Structure
- Shared package: ALU opcode constants (ADD, SUB, compare, plus the remaining five for completeness) and the state encoding.
- Single module. An optional sub-module `muldiv_carry32` computes the unsigned carry-out from a, b and sum.
- The ALU is instantiated at the datapath level, not inside this block.

## Test plan
- MUL 0xFFFF_FFFF × 0xFFFF_FFFF → `hi`=0xFFFF_FFFE, `lo`=0x0000_0001, `done` in cycle 33, `busy` high in cycles 1–33.
- MUL 12345 × 0 → `hi`=0, `lo`=0. Also MUL 0x8000_0000 × 2 → `hi`=1, `lo`=0.
- DIV 100 / 7 → `lo`=14, `hi`=2, `done` in cycle 65. DIV 0xFFFF_FFFF / 0x8000_0001 → `lo`=1, `hi`=0x7FFF_FFFE (exercises the MSB ge path).
- DIV 55 / 0 → `lo`=0xFFFF_FFFF, `hi`=55, `div_zero`=1, `done` in cycle 1. The next MUL clears `div_zero`.
- `start` pulsed during MUL and during FIN → ignored; the result is unchanged, and exactly one `done` pulse occurs per accepted start.
- `rst_n` dropped at cycle 20 of a DIV → all outputs at reset values asynchronously. A new MUL 3×5 afterwards gives `lo`=15.
